lc3_fetch_ctrl: RTL and testbench

- Sequences the LC3 fetch stage and the downstream pipeline enables.
- Drives enable_fetch, enable_updatePC and instrmem_rd into fetch, and enable_decode/enable_execute/enable_writeback into the later stages.
- Inserts stalls for data-memory accesses (direct and indirect) and bubbles for control transfers.
- Sits beside the fetch stage in the LC3 DUT. The fetch_in agent observes its fetch-side outputs.

---
 rtl/lc3_ctrl_pkg.sv | 28 ++
 rtl/lc3_stall_timer.sv | 41 ++++
 rtl/lc3_fetch_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_lc3_fetch_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC3 fetch/pipeline controller: data-memory
// state encodings, FSM state type and default timing constants.
package lc3_ctrl_pkg;

    // Encodings presented on mem_state
    localparam logic [1:0] MEM_RD   = 2'd0;
    localparam logic [1:0] MEM_IND  = 2'd1;
    localparam logic [1:0] MEM_WR   = 2'd2;
    localparam logic [1:0] MEM_IDLE = 2'd3;

    // Default timing constants
    localparam int BR_BUBBLES_DEFAULT  = 2;
    localparam int MEM_TIMEOUT_DEFAULT = 15;
    localparam int FILL_DEPTH_DEFAULT  = 3;

    // Wide enough for the largest legal MEM_TIMEOUT
    localparam int TIMER_WIDTH = 8;

    typedef enum logic [2:0] {
        S_RESET,
        S_FILL,
        S_RUN,
        S_MEM_IND,
        S_MEM,
        S_BUBBLE
    } fetch_ctrl_state_t;

endpackage

// File: rtl/lc3_stall_timer.sv
// Loadable down-counter with zero flag. One instance serves the fill,
// bubble and data-memory timeout counts since those phases never overlap.
// count_next is exposed so the owner can register outputs that depend on
// the value the counter is about to take.
module lc3_stall_timer
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count_next,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority over decrement; the count saturates at zero
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_value;
        end else if (dec && (count != '0)) begin
            count_next = count - WIDTH'(1);
        end
    end

    // Counter register, cleared by synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lc3_fetch_ctrl.sv
// LC3 fetch-stage and pipeline-enable sequencer. Fills the pipeline after
// reset or a control transfer, stalls for data-memory accesses (with an
// optional indirect-address phase and a timeout), and inserts bubbles after
// branches. Every output comes straight from a flop: the next-state logic
// also decides the outputs for the following cycle.
module lc3_fetch_ctrl
    import lc3_ctrl_pkg::*;
#(
    parameter int BR_BUBBLES  = BR_BUBBLES_DEFAULT,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int FILL_DEPTH  = FILL_DEPTH_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       complete_instr,
    input  logic       complete_data,
    input  logic       mem_req,
    input  logic       mem_write,
    input  logic       mem_indirect,
    input  logic       ctrl_xfer,
    input  logic       br_taken,
    output logic       enable_fetch,
    output logic       enable_updatePC,
    output logic       br_taken_out,
    output logic       instrmem_rd,
    output logic       enable_decode,
    output logic       enable_execute,
    output logic       enable_writeback,
    output logic [1:0] mem_state,
    output logic       mem_timeout_err
);

    fetch_ctrl_state_t state, next_state;

    logic                   tmr_load;
    logic                   tmr_dec;
    logic [TIMER_WIDTH-1:0] tmr_value;
    logic [TIMER_WIDTH-1:0] count_next;
    logic                   tmr_zero;

    // Store/load qualifier captured at request time, held through the access
    logic mem_write_q;
    logic nx_mem_write_q;

    logic       nx_fetch, nx_update_pc, nx_br_taken, nx_instrmem_rd;
    logic       nx_decode, nx_execute, nx_writeback, nx_timeout_err;
    logic [1:0] nx_mem_state;

    lc3_stall_timer #(
        .WIDTH(TIMER_WIDTH)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .dec        (tmr_dec),
        .count_next (count_next),
        .zero       (tmr_zero)
    );

    // Next-state, timer control and next-cycle output decode
    always_comb begin
        next_state     = state;
        tmr_load       = 1'b0;
        tmr_dec        = 1'b0;
        tmr_value      = '0;
        nx_mem_write_q = mem_write_q;
        nx_br_taken    = br_taken_out;
        nx_timeout_err = mem_timeout_err;
        nx_fetch       = 1'b0;
        nx_update_pc   = 1'b0;
        nx_instrmem_rd = 1'b0;
        nx_decode      = 1'b0;
        nx_execute     = 1'b0;
        nx_writeback   = 1'b0;
        nx_mem_state   = MEM_IDLE;

        case (state)
            S_RESET: begin
                next_state = S_FILL;
                tmr_load   = 1'b1;
                tmr_value  = TIMER_WIDTH'(FILL_DEPTH);
            end
            S_FILL: begin
                if (tmr_zero) begin
                    next_state = S_RUN;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_RUN: begin
                if (!complete_instr) begin
                    next_state = S_RUN;
                end else if (mem_req) begin
                    next_state     = mem_indirect ? S_MEM_IND : S_MEM;
                    nx_mem_write_q = mem_write;
                    tmr_load       = 1'b1;
                    tmr_value      = TIMER_WIDTH'(MEM_TIMEOUT - 1);
                end else if (ctrl_xfer) begin
                    next_state  = S_BUBBLE;
                    nx_br_taken = br_taken;
                    tmr_load    = 1'b1;
                    tmr_value   = TIMER_WIDTH'(BR_BUBBLES - 1);
                end
            end
            S_MEM_IND: begin
                if (complete_data) begin
                    next_state = S_MEM;
                    tmr_load   = 1'b1;
                    tmr_value  = TIMER_WIDTH'(MEM_TIMEOUT - 1);
                end else if (tmr_zero) begin
                    next_state     = S_RUN;
                    nx_timeout_err = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_MEM: begin
                if (complete_data) begin
                    next_state = S_RUN;
                end else if (tmr_zero) begin
                    next_state     = S_RUN;
                    nx_timeout_err = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_BUBBLE: begin
                if (tmr_zero) begin
                    next_state = S_FILL;
                    tmr_load   = 1'b1;
                    tmr_value  = TIMER_WIDTH'(FILL_DEPTH);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                next_state = S_RESET;
            end
        endcase

        case (next_state)
            S_FILL: begin
                nx_fetch       = 1'b1;
                nx_instrmem_rd = 1'b1;
                nx_update_pc   = 1'b1;
                nx_decode      = (count_next < TIMER_WIDTH'(FILL_DEPTH));
                nx_execute     = (count_next < TIMER_WIDTH'(FILL_DEPTH - 1));
                nx_writeback   = (count_next == '0);
            end
            S_RUN: begin
                if ((state == S_RUN) && !complete_instr) begin
                    nx_instrmem_rd = 1'b1;
                end else if ((state == S_MEM) || (state == S_MEM_IND)) begin
                    nx_instrmem_rd = 1'b1;
                    nx_writeback   = (state == S_MEM) && complete_data && !mem_write_q;
                end else begin
                    nx_fetch       = 1'b1;
                    nx_update_pc   = 1'b1;
                    nx_instrmem_rd = 1'b1;
                    nx_decode      = 1'b1;
                    nx_execute     = 1'b1;
                    nx_writeback   = 1'b1;
                end
            end
            S_MEM_IND: begin
                nx_mem_state = MEM_IND;
            end
            S_MEM: begin
                nx_mem_state = nx_mem_write_q ? MEM_WR : MEM_RD;
            end
            S_BUBBLE: begin
                nx_update_pc = (state == S_RUN);
                nx_writeback = (state == S_RUN);
            end
            default: begin
                nx_mem_state = MEM_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins over any phase in progress
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_RESET;
            mem_write_q      <= 1'b0;
            enable_fetch     <= 1'b0;
            enable_updatePC  <= 1'b0;
            br_taken_out     <= 1'b0;
            instrmem_rd      <= 1'b0;
            enable_decode    <= 1'b0;
            enable_execute   <= 1'b0;
            enable_writeback <= 1'b0;
            mem_state        <= MEM_IDLE;
            mem_timeout_err  <= 1'b0;
        end else begin
            state            <= next_state;
            mem_write_q      <= nx_mem_write_q;
            enable_fetch     <= nx_fetch;
            enable_updatePC  <= nx_update_pc;
            br_taken_out     <= nx_br_taken;
            instrmem_rd      <= nx_instrmem_rd;
            enable_decode    <= nx_decode;
            enable_execute   <= nx_execute;
            enable_writeback <= nx_writeback;
            mem_state        <= nx_mem_state;
            mem_timeout_err  <= nx_timeout_err;
        end
    end

    // A memory op and a control transfer can never share the execute stage
    illegal_mem_and_xfer: assert property (
        @(posedge clock) disable iff (reset)
        !((state == S_RUN) && mem_req && ctrl_xfer)
    );

endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
// Scoreboard bench for lc3_fetch_ctrl: each stimulus cycle queues the
// hand-computed output vector expected after the next clock edge; a monitor
// on the falling edge pops and compares independently.
module tb_lc3_fetch_ctrl;

    logic       clock;
    logic       reset;
    logic       complete_instr, complete_data, mem_req, mem_write;
    logic       mem_indirect, ctrl_xfer, br_taken;
    logic       enable_fetch, enable_updatePC, br_taken_out, instrmem_rd;
    logic       enable_decode, enable_execute, enable_writeback;
    logic [1:0] mem_state;
    logic       mem_timeout_err;

    typedef struct {
        int         cyc;
        logic [9:0] vec;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc          = 0;
    int   check_count  = 0;
    int   pass_count   = 0;

    lc3_fetch_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .mem_req          (mem_req),
        .mem_write        (mem_write),
        .mem_indirect     (mem_indirect),
        .ctrl_xfer        (ctrl_xfer),
        .br_taken         (br_taken),
        .enable_fetch     (enable_fetch),
        .enable_updatePC  (enable_updatePC),
        .br_taken_out     (br_taken_out),
        .instrmem_rd      (instrmem_rd),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .mem_state        (mem_state),
        .mem_timeout_err  (mem_timeout_err)
    );

    // 10-time-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle index, advanced on every rising edge
    always @(posedge clock) cyc <= cyc + 1;

    // Vector layout: fetch, updatePC, br_out, rd, decode, execute, wb, mem_state[1:0], err
    function automatic logic [9:0] vec(int f, int pc, int br, int rd, int d, int e, int w, int ms, int err);
        logic [1:0] m;
        m = ms[1:0];
        return {f[0], pc[0], br[0], rd[0], d[0], e[0], w[0], m, err[0]};
    endfunction

    function automatic logic [9:0] reset_v();
        return vec(0, 0, 0, 0, 0, 0, 0, 3, 0);
    endfunction
    function automatic logic [9:0] fill_v(int i, int br, int err);
        return vec(1, 1, br, 1, int'(i >= 1), int'(i >= 2), int'(i >= 3), 3, err);
    endfunction
    function automatic logic [9:0] run_v(int br, int err);
        return vec(1, 1, br, 1, 1, 1, 1, 3, err);
    endfunction
    function automatic logic [9:0] mem_v(int ms, int br, int err);
        return vec(0, 0, br, 0, 0, 0, 0, ms, err);
    endfunction
    function automatic logic [9:0] exit_v(int wb, int br, int err);
        return vec(0, 0, br, 1, 0, 0, wb, 3, err);
    endfunction
    function automatic logic [9:0] stall_v(int br, int err);
        return vec(0, 0, br, 1, 0, 0, 0, 3, err);
    endfunction
    function automatic logic [9:0] bub_v(int first, int br, int err);
        return vec(0, first, br, 0, 0, 0, first, 3, err);
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic applyStimulus(input int rst, input int ci, input int cd, input int mreq,
                                 input int mwr, input int mind, input int cx, input int bt,
                                 input logic [9:0] e, input string name);
        exp_t ent;
        reset          = rst[0];
        complete_instr = ci[0];
        complete_data  = cd[0];
        mem_req        = mreq[0];
        mem_write      = mwr[0];
        mem_indirect   = mind[0];
        ctrl_xfer      = cx[0];
        br_taken       = bt[0];
        ent.cyc  = cyc + 1;
        ent.vec  = e;
        ent.name = name;
        exp_q.push_back(ent);
        @(posedge clock);
        #1;
    endtask

    task automatic step(input int ci, input int cd, input int mreq, input int mwr,
                        input int mind, input int cx, input int bt,
                        input logic [9:0] e, input string name);
        applyStimulus(0, ci, cd, mreq, mwr, mind, cx, bt, e, name);
    endtask

    task automatic idle(input logic [9:0] e, input string name);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, e, name);
    endtask

    // Remaining fill cycles after the first fetch, then one RUN cycle
    task automatic fillTail(input int br, input int err);
        idle(fill_v(1, br, err), "fill1");
        idle(fill_v(2, br, err), "fill2");
        idle(fill_v(3, br, err), "fill3");
        idle(run_v(br, err), "run_after_fill");
    endtask

    // Control transfer: two bubble cycles, then refill
    task automatic bubbleSeq(input int bt, input int err);
        step(1, 0, 0, 0, 0, 1, bt, bub_v(1, bt, err), "bubble_first");
        idle(bub_v(0, bt, err), "bubble_second");
        idle(fill_v(0, bt, err), "refill0");
        fillTail(bt, err);
    endtask

    task automatic checkOutput(input exp_t ent);
        logic [9:0] act;
        act = {enable_fetch, enable_updatePC, br_taken_out, instrmem_rd, enable_decode,
               enable_execute, enable_writeback, mem_state, mem_timeout_err};
        check_count++;
        if (act === ent.vec && ent.cyc == cyc) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s cycle %0d (due %0d): got %b expected %b",
                     ent.name, cyc, ent.cyc, act, ent.vec);
        end
    endtask

    // Monitor: compare whenever an expectation falls due
    always @(negedge clock) begin
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        complete_instr = 1'b1;
        complete_data = 1'b0;
        mem_req = 1'b0;
        mem_write = 1'b0;
        mem_indirect = 1'b0;
        ctrl_xfer = 1'b0;
        br_taken = 1'b0;
        @(posedge clock);
        #1;

        $display("[TB] reset and pipeline fill");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, reset_v(), "reset0");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, reset_v(), "reset1");
        idle(fill_v(0, 0, 0), "fill0");
        fillTail(0, 0);
        idle(run_v(0, 0), "run");

        $display("[TB] instruction memory stall, priority over mem_req");
        step(0, 0, 1, 0, 0, 0, 0, stall_v(0, 0), "istall_memreq");
        step(0, 0, 0, 0, 0, 0, 0, stall_v(0, 0), "istall");
        idle(run_v(0, 0), "istall_release");

        $display("[TB] LDR, data ready in fourth cycle");
        step(1, 0, 1, 0, 0, 0, 0, mem_v(0, 0, 0), "ldr_m1");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, mem_v(0, 0, 0), "ldr_wait");
        step(1, 1, 0, 0, 0, 0, 0, exit_v(1, 0, 0), "ldr_exit_wb");
        idle(run_v(0, 0), "ldr_run");

        $display("[TB] STI, address phase then write phase");
        step(1, 0, 1, 1, 1, 0, 0, mem_v(1, 0, 0), "sti_ind1");
        step(1, 0, 0, 1, 0, 0, 0, mem_v(1, 0, 0), "sti_ind2");
        step(1, 1, 0, 1, 0, 0, 0, mem_v(2, 0, 0), "sti_wr3");
        step(1, 0, 0, 1, 0, 0, 0, mem_v(2, 0, 0), "sti_wr4");
        step(1, 0, 0, 1, 0, 0, 0, mem_v(2, 0, 0), "sti_wr5");
        step(1, 1, 0, 1, 0, 0, 0, exit_v(0, 0, 0), "sti_exit_nowb");
        idle(run_v(0, 0), "sti_run");

        $display("[TB] taken and not-taken control transfers");
        bubbleSeq(1, 0);
        bubbleSeq(0, 0);

        $display("[TB] data arrives on the last allowed cycle");
        step(1, 0, 1, 0, 0, 0, 0, mem_v(0, 0, 0), "late_m1");
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 0, 0, 0, mem_v(0, 0, 0), "late_wait");
        step(1, 1, 0, 0, 0, 0, 0, exit_v(1, 0, 0), "late_exit_noerr");
        idle(run_v(0, 0), "late_run");

        $display("[TB] data never arrives");
        step(1, 0, 1, 1, 0, 0, 0, mem_v(2, 0, 0), "to_m1");
        for (int i = 0; i < 14; i++) step(1, 0, 0, 1, 0, 0, 0, mem_v(2, 0, 0), "to_wait");
        step(1, 0, 0, 1, 0, 0, 0, exit_v(0, 0, 1), "to_exit_err");
        idle(run_v(0, 1), "to_run_sticky");
        bubbleSeq(1, 1);
        step(1, 0, 1, 0, 0, 0, 0, mem_v(0, 1, 1), "quick_m1");
        step(1, 1, 0, 0, 0, 0, 0, exit_v(1, 1, 1), "quick_exit_sticky");
        idle(run_v(1, 1), "quick_run");

        $display("[TB] reset in the middle of an indirect access");
        step(1, 0, 1, 0, 1, 0, 0, mem_v(1, 1, 1), "mid_ind1");
        step(1, 0, 0, 0, 0, 0, 0, mem_v(1, 1, 1), "mid_ind2");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, reset_v(), "mid_reset");
        idle(fill_v(0, 0, 0), "re_fill0");
        fillTail(0, 0);
        idle(run_v(0, 0), "re_run");

        repeat (3) @(posedge clock);
        #1;
        if (exp_q.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
            check_count += exp_q.size();
        end
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
